// File: rtl/ex_mem_skid_reg.sv
// EX->MEM pipeline register with a 2-entry skid buffer; ex_ready is driven from flops only.
// Optional EX_MEM_FWD_EN adds EX operand forwarding outputs taken from the output entry.
//
// state | meaning
// EMPTY | no entry held; ex_ready=1, mem_valid=0
// ONE   | output entry valid; ex_ready=1
// FULL  | output and skid entries valid; ex_ready=0
module ex_mem_skid_reg #(
   parameter int DATA_WIDTH     = 32,
   parameter int REG_ADDR_WIDTH = 5
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      flush,
   input  logic                      ex_valid,
   output logic                      ex_ready,
   input  logic [DATA_WIDTH-1:0]     ex_alu_result,
   input  logic [DATA_WIDTH-1:0]     ex_store_data,
   input  logic [DATA_WIDTH-1:0]     ex_pc,
   input  logic [REG_ADDR_WIDTH-1:0] ex_rd_addr,
   input  logic [2:0]                ex_func3,
   input  logic                      ex_reg_write,
   input  logic                      ex_mem_read,
   input  logic                      ex_mem_write,
   output logic                      mem_valid,
   input  logic                      mem_ready,
   output logic [DATA_WIDTH-1:0]     mem_alu_result,
   output logic [DATA_WIDTH-1:0]     mem_store_data,
   output logic [DATA_WIDTH-1:0]     mem_pc,
   output logic [REG_ADDR_WIDTH-1:0] mem_rd_addr,
   output logic [2:0]                mem_func3,
   output logic                      mem_reg_write,
   output logic                      mem_mem_read,
   output logic                      mem_mem_write
`ifdef EX_MEM_FWD_EN
   ,
   output logic                      fwd_valid,
   output logic [REG_ADDR_WIDTH-1:0] fwd_rd_addr,
   output logic [DATA_WIDTH-1:0]     fwd_data
`endif
);

   localparam int PW = 3*DATA_WIDTH + REG_ADDR_WIDTH + 6;

   // bit 0 = output entry valid, bit 1 = skid entry valid
   typedef enum logic [1:0] {
      EMPTY = 2'b00,
      ONE   = 2'b01,
      FULL  = 2'b11
   } state_t;

   state_t          state, state_nxt;
   logic            accept, deliver;
   logic            load_out, load_skid, out_from_skid;
   logic [PW-1:0]   in_pl, out_pl, skid_pl;

   assign in_pl = {ex_alu_result, ex_store_data, ex_pc, ex_rd_addr,
                   ex_func3, ex_reg_write, ex_mem_read, ex_mem_write};

   assign {mem_alu_result, mem_store_data, mem_pc, mem_rd_addr,
           mem_func3, mem_reg_write, mem_mem_read, mem_mem_write} = out_pl;

   assign mem_valid = state[0];
   assign ex_ready  = ~state[1];
   assign accept    = ex_valid & ex_ready;
   assign deliver   = mem_valid & mem_ready;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= EMPTY;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      load_out      = 1'b0;
      load_skid     = 1'b0;
      out_from_skid = 1'b0;
      case (state)
         EMPTY: begin
            if (accept) begin
               state_nxt = ONE;
               load_out  = 1'b1;
            end
         end
         ONE: begin
            if (accept && deliver) begin
               load_out = 1'b1;
            end else if (accept) begin
               state_nxt = FULL;
               load_skid = 1'b1;
            end else if (deliver) begin
               state_nxt = EMPTY;
            end
         end
         FULL: begin
            if (deliver) begin
               state_nxt     = ONE;
               load_out      = 1'b1;
               out_from_skid = 1'b1;
            end
         end
         default: state_nxt = EMPTY;
      endcase
      // a redirect squashes everything, including an entry arriving this cycle
      if (flush) begin
         state_nxt     = EMPTY;
         load_out      = 1'b0;
         load_skid     = 1'b0;
         out_from_skid = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_pl  <= '0;
         skid_pl <= '0;
      end else begin
         if (load_out) begin
            out_pl <= out_from_skid ? skid_pl : in_pl;
         end
         if (load_skid) begin
            skid_pl <= in_pl;
         end
      end
   end

`ifdef EX_MEM_FWD_EN
   // loads are excluded: their data is not known until MEM completes
   assign fwd_valid   = mem_valid & mem_reg_write & ~mem_mem_read & (mem_rd_addr != '0);
   assign fwd_rd_addr = mem_rd_addr;
   assign fwd_data    = mem_alu_result;
`endif

endmodule
